// File: rtl/ides4_pkg.sv
// Shared types and default constants for the 4-bit word aligner.
package ides4_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SETTLE = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } align_state_t;

  localparam logic [3:0] DEF_TRAIN_PAT  = 4'b0101;
  localparam int         DEF_LOCK_CNT   = 4;
  localparam int         DEF_UNLOCK_CNT = 2;
  localparam int         DEF_SLIP_WAIT  = 2;

  // Width of a counter that must hold values 0..max_val (never below 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ides4_gearbox.sv
// Serial-to-4-bit gearbox: shift register, word phase and one-bit slip.
module ides4_gearbox (
  input  logic       clk,
  input  logic       nrst,
  input  logic       ser,
  input  logic       en,
  input  logic       slip_req,
  output logic [3:0] word,
  output logic       word_vld
);

  logic [3:0] shift_reg;
  logic [3:0] shift_next;
  logic [1:0] phase_reg;
  logic       pend_reg;
  logic [3:0] word_reg;
  logic       word_vld_reg;
  logic       take_word;

  // Bit 0 of the word is the oldest bit, so new bits enter at the top.
  assign shift_next = {ser, shift_reg[3:1]};

  // A slipped bit is absorbed without advancing the phase, so it never closes a word.
  assign take_word = en && !pend_reg && (phase_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      shift_reg    <= '0;
      phase_reg    <= '0;
      pend_reg     <= 1'b0;
      word_reg     <= '0;
      word_vld_reg <= 1'b0;
    end else begin
      word_vld_reg <= take_word;
      if (take_word) begin
        word_reg <= shift_next;
      end
      if (en) begin
        shift_reg <= shift_next;
        if (!pend_reg) begin
          phase_reg <= phase_reg + 2'd1;
        end
      end
      // A request arriving with a strobe waits for the next strobe.
      if (slip_req) begin
        pend_reg <= 1'b1;
      end else if (en) begin
        pend_reg <= 1'b0;
      end
    end
  end

  assign word     = word_reg;
  assign word_vld = word_vld_reg;

endmodule

// File: rtl/ides4_align.sv
// Word aligner: hunts for the training word by bitslipping, then tracks lock.
module ides4_align
  import ides4_pkg::*;
#(
  parameter logic [3:0] TRAIN_PAT  = DEF_TRAIN_PAT,
  parameter int         LOCK_CNT   = DEF_LOCK_CNT,
  parameter int         UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int         SLIP_WAIT  = DEF_SLIP_WAIT
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       ser_i,
  input  logic       en_i,
  output logic [3:0] word_o,
  output logic       word_vld_o,
  output logic       locked_o,
  output logic       slip_o,
  output logic [7:0] err_cnt_o
);

  localparam int MW = cnt_width(LOCK_CNT);
  localparam int UW = cnt_width(UNLOCK_CNT);
  localparam int SW = cnt_width(SLIP_WAIT);

  align_state_t  state_reg, state_next;
  logic [MW-1:0] match_reg, match_next;
  logic [UW-1:0] miss_reg, miss_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic [7:0]    err_reg, err_next;
  logic          slip_reg, slip_next;
  logic [3:0]    word;
  logic          word_vld;
  logic          is_match;

  ides4_gearbox u_gearbox (
    .clk      (clk_i),
    .nrst     (nrst_i),
    .ser      (ser_i),
    .en       (en_i),
    .slip_req (slip_next),
    .word     (word),
    .word_vld (word_vld)
  );

  assign is_match = (word == TRAIN_PAT);

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_reg  <= HUNT;
      match_reg  <= '0;
      miss_reg   <= '0;
      settle_reg <= '0;
      err_reg    <= '0;
      slip_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      match_reg  <= match_next;
      miss_reg   <= miss_next;
      settle_reg <= settle_next;
      err_reg    <= err_next;
      slip_reg   <= slip_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    match_next  = match_reg;
    miss_next   = miss_reg;
    settle_next = settle_reg;
    err_next    = err_reg;
    slip_next   = 1'b0;
    if (word_vld) begin
      case (state_reg)
        HUNT: begin
          if (is_match) begin
            match_next = MW'(1);
            state_next = (LOCK_CNT <= 1) ? LOCKED : VERIFY;
          end else begin
            slip_next   = 1'b1;
            settle_next = '0;
            state_next  = (SLIP_WAIT == 0) ? HUNT : SETTLE;
          end
        end
        SETTLE: begin
          // Words straddling the old and new boundary are not compared.
          if (int'(settle_reg) + 1 >= SLIP_WAIT) begin
            settle_next = '0;
            state_next  = HUNT;
          end else begin
            settle_next = settle_reg + SW'(1);
          end
        end
        VERIFY: begin
          if (is_match) begin
            match_next = match_reg + MW'(1);
            if (int'(match_reg) + 1 >= LOCK_CNT) begin
              state_next = LOCKED;
            end
          end else begin
            slip_next   = 1'b1;
            settle_next = '0;
            match_next  = '0;
            state_next  = (SLIP_WAIT == 0) ? HUNT : SETTLE;
          end
        end
        LOCKED: begin
          if (is_match) begin
            miss_next = '0;
          end else begin
            err_next = (err_reg == 8'hFF) ? err_reg : err_reg + 8'd1;
            if (int'(miss_reg) + 1 >= UNLOCK_CNT) begin
              miss_next  = '0;
              match_next = '0;
              state_next = HUNT;
            end else begin
              miss_next = miss_reg + UW'(1);
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  assign word_o     = word;
  assign word_vld_o = word_vld;
  assign locked_o   = (state_reg == LOCKED);
  assign slip_o     = slip_reg;
  assign err_cnt_o  = err_reg;

endmodule

// File: tb/tb_ides4_align.sv
// Directed bench for ides4_align: three instances share one stimulus stream.
module tb_ides4_align;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       ser = 1'b0;
  logic       en = 1'b0;

  logic [3:0] word_a, word_b, word_c;
  logic       vld_a, vld_b, vld_c;
  logic       locked_a, locked_b, locked_c;
  logic       slip_a, slip_b, slip_c;
  logic [7:0] err_a, err_b, err_c;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ides4_align dut_a (
    .clk_i(clk), .nrst_i(nrst), .ser_i(ser), .en_i(en),
    .word_o(word_a), .word_vld_o(vld_a), .locked_o(locked_a),
    .slip_o(slip_a), .err_cnt_o(err_a)
  );

  ides4_align #(.TRAIN_PAT(4'b0011)) dut_b (
    .clk_i(clk), .nrst_i(nrst), .ser_i(ser), .en_i(en),
    .word_o(word_b), .word_vld_o(vld_b), .locked_o(locked_b),
    .slip_o(slip_b), .err_cnt_o(err_b)
  );

  ides4_align #(.UNLOCK_CNT(1000)) dut_c (
    .clk_i(clk), .nrst_i(nrst), .ser_i(ser), .en_i(en),
    .word_o(word_c), .word_vld_o(vld_c), .locked_o(locked_c),
    .slip_o(slip_c), .err_cnt_o(err_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic put_bit(input logic b);
    ser = b;
    en  = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int k = 0; k < 4; k++) put_bit(w[k]);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    en   = 1'b0;
    ser  = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    en   = 1'b0;
    ser  = 1'b0;
    tick();
    tick();
    total++;
    if ({word_a, vld_a, locked_a, slip_a} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000000", {word_a, vld_a, locked_a, slip_a});
    end
    total++;
    if (err_a !== 8'd0) begin
      bad++;
      $display("FAIL reset_err got=%0d want=0", err_a);
    end
    nrst = 1'b1;
  endtask

  task automatic test_aligned();
    int nvld = 0;
    for (int i = 1; i <= 20; i++) begin
      put_bit(i[0]);
      total++;
      if (slip_a !== 1'b0) begin
        bad++;
        $display("FAIL aligned_slip bit=%0d got=%b want=0", i, slip_a);
      end
      if (vld_a === 1'b1) begin
        nvld++;
        total++;
        if (word_a !== 4'b0101) begin
          bad++;
          $display("FAIL aligned_word n=%0d got=%b want=0101", nvld, word_a);
        end
      end
      if (i == 16) begin
        total++;
        if (nvld != 4 || locked_a !== 1'b0) begin
          bad++;
          $display("FAIL aligned_prelock vld=%0d locked=%b want vld=4 locked=0", nvld, locked_a);
        end
      end
      if (i == 17) begin
        total++;
        if (locked_a !== 1'b1) begin
          bad++;
          $display("FAIL aligned_lock got=%b want=1", locked_a);
        end
      end
    end
  endtask

  task automatic test_loss();
    send_word(4'b1111);
    total++;
    if (vld_a !== 1'b1 || word_a !== 4'b1111) begin
      bad++;
      $display("FAIL loss_badword vld=%b word=%b want vld=1 word=1111", vld_a, word_a);
    end
    send_word(4'b0101);
    total++;
    if (err_a !== 8'd1 || locked_a !== 1'b1) begin
      bad++;
      $display("FAIL loss_single err=%0d locked=%b want err=1 locked=1", err_a, locked_a);
    end
    send_word(4'b1111);
    send_word(4'b1111);
    total++;
    if (locked_a !== 1'b1) begin
      bad++;
      $display("FAIL loss_before_drop locked=%b want=1", locked_a);
    end
    en = 1'b0;
    tick();
    total++;
    if (locked_a !== 1'b0 || err_a !== 8'd3) begin
      bad++;
      $display("FAIL loss_drop locked=%b err=%0d want locked=0 err=3", locked_a, err_a);
    end
    for (int w = 0; w < 4; w++) send_word(4'b0101);
    en = 1'b0;
    tick();
    total++;
    if (locked_a !== 1'b1 || err_a !== 8'd3) begin
      bad++;
      $display("FAIL loss_relock locked=%b err=%0d want locked=1 err=3", locked_a, err_a);
    end
  endtask

  task automatic test_strobed();
    int last = -1;
    int nvld = 0;
    logic [3:0] held;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      ser = i[0];
      en  = 1'b1;
      tick();
      if (vld_a === 1'b1) begin
        nvld++;
        total++;
        if (word_a !== 4'b0101) begin
          bad++;
          $display("FAIL strobe_word n=%0d got=%b want=0101", nvld, word_a);
        end
        if (last >= 0) begin
          total++;
          if (cyc - last != 16) begin
            bad++;
            $display("FAIL strobe_spacing got=%0d want=16", cyc - last);
          end
        end
        last = cyc;
      end
      held = word_a;
      en   = 1'b0;
      ser  = ~i[0];
      tick();
      tick();
      tick();
      total++;
      if (word_a !== held || vld_a !== 1'b0) begin
        bad++;
        $display("FAIL strobe_hold word=%b vld=%b want word=%b vld=0", word_a, vld_a, held);
      end
    end
    total++;
    if (nvld != 5 || locked_a !== 1'b1) begin
      bad++;
      $display("FAIL strobe_lock vld=%0d locked=%b want vld=5 locked=1", nvld, locked_a);
    end
  endtask

  task automatic test_offset();
    logic [3:0] pat = 4'b0011;
    int slips = 0;
    int slips_at_match = -1;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      put_bit(pat[(n + 1) % 4]);
      if (slip_b === 1'b1) slips++;
      if (vld_b === 1'b1 && word_b == 4'b0011 && slips_at_match < 0) slips_at_match = slips;
    end
    total++;
    if (slips_at_match != 3) begin
      bad++;
      $display("FAIL offset_slips_before_match got=%0d want=3", slips_at_match);
    end
    total++;
    if (slips != 3) begin
      bad++;
      $display("FAIL offset_slips_total got=%0d want=3", slips);
    end
    total++;
    if (locked_b !== 1'b1) begin
      bad++;
      $display("FAIL offset_lock got=%b want=1", locked_b);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 20; i++) put_bit(i[0]);
    total++;
    if (locked_c !== 1'b1) begin
      bad++;
      $display("FAIL sat_initial_lock got=%b want=1", locked_c);
    end
    for (int w = 0; w < 300; w++) send_word(4'b1111);
    total++;
    if (err_c !== 8'd255 || locked_c !== 1'b1) begin
      bad++;
      $display("FAIL sat_err err=%0d locked=%b want err=255 locked=1", err_c, locked_c);
    end
    put_bit(1'b1);
    put_bit(1'b0);
    nrst = 1'b0;
    ser  = 1'b1;
    en   = 1'b1;
    tick();
    total++;
    if ({word_c, vld_c, locked_c, slip_c} !== 7'b0 || err_c !== 8'd0) begin
      bad++;
      $display("FAIL sat_reset out=%b err=%0d want out=0000000 err=0",
               {word_c, vld_c, locked_c, slip_c}, err_c);
    end
    nrst = 1'b1;
    for (int i = 1; i <= 16; i++) put_bit(i[0]);
    total++;
    if (locked_c !== 1'b0 || word_c !== 4'b0101) begin
      bad++;
      $display("FAIL sat_prelock locked=%b word=%b want locked=0 word=0101", locked_c, word_c);
    end
    en = 1'b0;
    tick();
    total++;
    if (locked_c !== 1'b1) begin
      bad++;
      $display("FAIL sat_relock got=%b want=1", locked_c);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_loss();
    test_strobed();
    test_offset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
